dma_engine: RTL and testbench

//  Memory-to-memory copy engine sharing the single-port SRAM with CTL.
//  CTL programs src/dst/len and pulses start; the engine copies len 32-bit words
//  in increasing address order, using only the cycles in which CTL leaves the

---
 rtl/dma_engine.sv | 103 ++++++++++
 tb/tb_dma_engine.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_engine.sv
// dma_engine: word-by-word SRAM copy engine that steals idle cycles from CTL.
// Optional DMA_PROGRESS_EN exposes the remaining-word counter as dma_remaining.
module dma_engine #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [ADDR_W-1:0] len,
   input  logic              cpu_sram_en,
   input  logic [DATA_W-1:0] sram_DO,
   output logic [ADDR_W-1:0] dma_sram_ADDR,
   output logic [DATA_W-1:0] dma_sram_DI,
   output logic              dma_sram_EN,
   output logic              dma_sram_WE,
   output logic              busy,
   output logic              done
`ifdef DMA_PROGRESS_EN
   ,
   output logic [ADDR_W-1:0] dma_remaining
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_CAP,
      S_WR,
      S_DONE
   } state_t;

   localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

   state_t            state_q;
   logic [ADDR_W-1:0] src_q;
   logic [ADDR_W-1:0] dst_q;
   logic [ADDR_W-1:0] rem_q;
   logic [DATA_W-1:0] data_q;
   logic              rd_go;
   logic              wr_go;

   // Accesses only happen when CTL has left the SRAM idle this cycle
   assign rd_go = (state_q == S_RD) && !cpu_sram_en;
   assign wr_go = (state_q == S_WR) && !cpu_sram_en;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         rem_q   <= '0;
         data_q  <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  if (len != '0) begin
                     src_q   <= src_addr;
                     dst_q   <= dst_addr;
                     rem_q   <= len;
                     state_q <= S_RD;
                  end else begin
                     state_q <= S_DONE;
                  end
               end
            end
            S_RD: begin
               if (!cpu_sram_en) state_q <= S_CAP;
            end
            S_CAP: begin
               data_q  <= sram_DO;
               state_q <= S_WR;
            end
            S_WR: begin
               if (!cpu_sram_en) begin
                  src_q   <= src_q + ONE;
                  dst_q   <= dst_q + ONE;
                  rem_q   <= rem_q - ONE;
                  state_q <= (rem_q == ONE) ? S_DONE : S_RD;
               end
            end
            S_DONE: state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign dma_sram_EN   = rd_go | wr_go;
   assign dma_sram_WE   = wr_go;
   assign dma_sram_ADDR = rd_go ? src_q : (wr_go ? dst_q : '0);
   assign dma_sram_DI   = wr_go ? data_q : '0;

   assign busy = (state_q == S_RD) || (state_q == S_CAP) || (state_q == S_WR);
   assign done = (state_q == S_DONE);

`ifdef DMA_PROGRESS_EN
   assign dma_remaining = rem_q;
`endif

endmodule

// File: tb/tb_dma_engine.sv
// tb_dma_engine: vector table of copies against a behavioural SRAM,
// plus hand sequences for reset abort and start-while-busy.
module tb_dma_engine;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] src_addr;
   logic [15:0] dst_addr;
   logic [15:0] len;
   logic        cpu_sram_en;
   logic [31:0] sram_DO;
   logic [15:0] dma_sram_ADDR;
   logic [31:0] dma_sram_DI;
   logic        dma_sram_EN;
   logic        dma_sram_WE;
   logic        busy;
   logic        done;
`ifdef DMA_PROGRESS_EN
   logic [15:0] dma_remaining;
`endif

   dma_engine dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .src_addr     (src_addr),
      .dst_addr     (dst_addr),
      .len          (len),
      .cpu_sram_en  (cpu_sram_en),
      .sram_DO      (sram_DO),
      .dma_sram_ADDR(dma_sram_ADDR),
      .dma_sram_DI  (dma_sram_DI),
      .dma_sram_EN  (dma_sram_EN),
      .dma_sram_WE  (dma_sram_WE),
      .busy         (busy),
      .done         (done)
`ifdef DMA_PROGRESS_EN
      ,
      .dma_remaining(dma_remaining)
`endif
   );

   always #5 clk = ~clk;

   // Shared single-port SRAM: CTL reads a scratch word when it owns the cycle
   logic [31:0] mem [0:65535];
   logic        s_en;
   logic [15:0] s_addr;
   assign s_en   = dma_sram_EN | cpu_sram_en;
   assign s_addr = dma_sram_ADDR | (cpu_sram_en ? 16'h3000 : 16'h0000);

   always @(posedge clk) begin
      if (s_en) begin
         if (dma_sram_WE) mem[s_addr] = dma_sram_DI;
         else sram_DO <= mem[s_addr];
      end
   end

   int n_cmp = 0;
   int n_fail = 0;
   int remq[$];
   int rem_done;

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] pat(input int v, input int i);
      return 32'hA000_0000 + 32'(v * 256) + 32'(i);
   endfunction

   // One command; counts are taken at negedge, cycle 0 is the start cycle
   task automatic run(input logic [15:0] s, input logic [15:0] d,
                      input logic [15:0] l, input int cont,
                      input int restart_at, input int abort_after,
                      output int done_at, output int busy_n,
                      output int en_n, output int bad_n, output int done_n);
      int wr;
      int stop;
      bit pend;
      done_at = -1;
      busy_n = 0;
      en_n = 0;
      bad_n = 0;
      done_n = 0;
      wr = 0;
      pend = 0;
      stop = 200;
      remq.delete();
      rem_done = -1;
      @(posedge clk); #1;
      start = 1'b1;
      src_addr = s;
      dst_addr = d;
      len = l;
      for (int c = 0; c < stop; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
            start = 1'b0;
            reset = 1'b0;
            if (pend) begin
               reset = 1'b1;
               pend = 0;
               stop = c + 12;
            end
         end
         if (c == restart_at) begin
            start = 1'b1;
            src_addr = 16'h0C00;
         end
         cpu_sram_en = (cont != 0) && (c % 2 == 0);
         @(negedge clk);
         if (dma_sram_EN && cpu_sram_en) bad_n++;
         if (!dma_sram_EN && (dma_sram_ADDR != 0 || dma_sram_DI != 0 || dma_sram_WE))
            bad_n++;
         if (dma_sram_EN) en_n++;
         if (busy) busy_n++;
         if (dma_sram_EN && dma_sram_WE) begin
            wr++;
`ifdef DMA_PROGRESS_EN
            remq.push_back(int'(dma_remaining));
`endif
            if (abort_after != 0 && wr == abort_after) pend = 1;
         end
         if (done) begin
            done_n++;
            if (done_at < 0) begin
               done_at = c;
               stop = c + 3;
`ifdef DMA_PROGRESS_EN
               rem_done = int'(dma_remaining);
`endif
            end
         end
      end
      @(posedge clk); #1;
      start = 1'b0;
      reset = 1'b0;
      cpu_sram_en = 1'b0;
   endtask

   typedef struct {
      logic [15:0] src;
      logic [15:0] dst;
      logic [15:0] len;
      int          cont;
      bit          ovl;
      int          exp_done;
      int          exp_busy;
      int          exp_en;
   } vec_t;

   vec_t vt [6];

   task automatic prep(input int v, input logic [15:0] s, input logic [15:0] d,
                       input logic [15:0] l);
      for (int i = 0; i <= int'(l); i++) mem[d + 16'(i)] = 32'hDEAD_0000 + 32'(i);
      for (int i = 0; i < int'(l); i++) mem[s + 16'(i)] = pat(v, i);
   endtask

   initial begin
      int da, bn, en, bd, dn;
      logic [31:0] exp_w;
      vt[0] = '{16'h0100, 16'h0200, 16'd4, 0, 1'b0, 13, 12, 8};
      vt[1] = '{16'h0300, 16'h0400, 16'd0, 0, 1'b0, 1, 0, 0};
      vt[2] = '{16'h0500, 16'h0600, 16'd3, 1, 1'b0, 12, 11, 6};
      vt[3] = '{16'hFFFF, 16'h0010, 16'd2, 0, 1'b0, 7, 6, 4};
      vt[4] = '{16'h0700, 16'h0701, 16'd3, 0, 1'b1, 10, 9, 6};
      vt[5] = '{16'h2000, 16'h2100, 16'd1, 0, 1'b0, 4, 3, 2};

      reset = 1'b1;
      start = 1'b0;
      src_addr = '0;
      dst_addr = '0;
      len = '0;
      cpu_sram_en = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_en", dma_sram_EN, 0);
      chk("rst_we", dma_sram_WE, 0);
      chk("rst_addr", dma_sram_ADDR, 0);
      chk("rst_di", dma_sram_DI, 0);
`ifdef DMA_PROGRESS_EN
      chk("rst_rem", dma_remaining, 0);
`endif

      for (int v = 0; v < 6; v++) begin
         prep(v, vt[v].src, vt[v].dst, vt[v].len);
         run(vt[v].src, vt[v].dst, vt[v].len, vt[v].cont, -1, 0, da, bn, en, bd, dn);
         chk($sformatf("v%0d_done_cyc", v), da, vt[v].exp_done);
         chk($sformatf("v%0d_done_cnt", v), dn, 1);
         chk($sformatf("v%0d_busy", v), bn, vt[v].exp_busy);
         chk($sformatf("v%0d_en", v), en, vt[v].exp_en);
         chk($sformatf("v%0d_conflict", v), bd, 0);
         for (int i = 0; i < int'(vt[v].len); i++) begin
            exp_w = pat(v, vt[v].ovl ? 0 : i);
            chk($sformatf("v%0d_dst%0d", v, i), mem[vt[v].dst + 16'(i)], exp_w);
         end
         chk($sformatf("v%0d_sentinel", v), mem[vt[v].dst + vt[v].len],
             32'hDEAD_0000 + 32'(vt[v].len));
      end

      // Reset after the second of five writes
      prep(8, 16'h0800, 16'h0900, 16'd5);
      run(16'h0800, 16'h0900, 16'd5, 0, -1, 2, da, bn, en, bd, dn);
      chk("abort_done_cnt", dn, 0);
      chk("abort_busy_cyc", bn, 7);
      chk("abort_busy_now", busy, 0);
      chk("abort_en_now", dma_sram_EN, 0);
      chk("abort_w0", mem[16'h0900], pat(8, 0));
      chk("abort_w1", mem[16'h0901], pat(8, 1));
      chk("abort_w2", mem[16'h0902], 32'hDEAD_0002);
      chk("abort_w3", mem[16'h0903], 32'hDEAD_0003);
      chk("abort_w4", mem[16'h0904], 32'hDEAD_0004);
      prep(9, 16'h2200, 16'h2300, 16'd2);
      run(16'h2200, 16'h2300, 16'd2, 0, -1, 0, da, bn, en, bd, dn);
      chk("post_abort_done", da, 7);
      chk("post_abort_w0", mem[16'h2300], pat(9, 0));
      chk("post_abort_w1", mem[16'h2301], pat(9, 1));

      // Second start with another source while busy must be ignored
      prep(10, 16'h0A00, 16'h0B00, 16'd4);
      for (int i = 0; i < 4; i++) mem[16'h0C00 + 16'(i)] = 32'h5555_0000 + 32'(i);
      run(16'h0A00, 16'h0B00, 16'd4, 0, 2, 0, da, bn, en, bd, dn);
      chk("busy_start_done", da, 13);
      chk("busy_start_cnt", dn, 1);
      for (int i = 0; i < 4; i++)
         chk($sformatf("busy_start_w%0d", i), mem[16'h0B00 + 16'(i)], pat(10, i));
`ifdef DMA_PROGRESS_EN
      chk("rem_n", remq.size(), 4);
      for (int i = 0; i < remq.size(); i++)
         chk($sformatf("rem_wr%0d", i), remq[i], 4 - i);
      chk("rem_done", rem_done, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
